// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment driver for the up/down counter: shows the count in decimal,
// the direction as U/d, and flags a wrap-around on the units decimal point. Values change only between frames.
module seg_scan_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       dir_in,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_D     = 7'h21;

    logic [PW-1:0] prescaler_reg;
    logic [1:0]    idx_reg;
    logic [3:0]    pend_cnt_reg;
    logic          pend_dir_reg;
    logic [3:0]    disp_cnt_reg;
    logic          disp_dir_reg;
    logic          wrap_reg;

    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic [3:0]    an_reg;
    logic          frame_tick_reg;

    logic          slot_end;
    logic          frame_end;
    logic          wrap_next;
    logic [3:0]    units;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    assign slot_end  = (prescaler_reg == PW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx_reg == 2'd3);

    // Wrap is judged against the value being replaced, i.e. the old display register.
    assign wrap_next = ( pend_dir_reg && (disp_cnt_reg == 4'd15) && (pend_cnt_reg == 4'd0)) ||
                       (!pend_dir_reg && (disp_cnt_reg == 4'd0)  && (pend_cnt_reg == 4'd15));

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg <= '0;
            idx_reg       <= 2'd0;
        end else if (slot_end) begin
            prescaler_reg <= '0;
            idx_reg       <= idx_reg + 2'd1;
        end else begin
            prescaler_reg <= prescaler_reg + PW'(1);
        end
    end

    // A load coinciding with the boundary goes to pend only; disp takes the previous pend.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt_reg <= 4'd0;
            pend_dir_reg <= 1'b1;
            disp_cnt_reg <= 4'd0;
            disp_dir_reg <= 1'b1;
            wrap_reg     <= 1'b0;
        end else begin
            if (load) begin
                pend_cnt_reg <= count_in;
                pend_dir_reg <= dir_in;
            end
            if (frame_end) begin
                disp_cnt_reg <= pend_cnt_reg;
                disp_dir_reg <= pend_dir_reg;
                wrap_reg     <= wrap_next;
            end
        end
    end

    assign units = (disp_cnt_reg >= 4'd10) ? (disp_cnt_reg - 4'd10) : disp_cnt_reg;

    always_comb begin
        seg_next = SEG_BLANK;
        case (idx_reg)
            2'd0:    seg_next = digit_code(units);
            2'd1:    seg_next = (disp_cnt_reg >= 4'd10) ? digit_code(4'd1) : SEG_BLANK;
            2'd2:    seg_next = SEG_BLANK;
            default: seg_next = disp_dir_reg ? SEG_U : SEG_D;
        endcase
    end

    assign dp_next = !((idx_reg == 2'd0) && wrap_reg && !blank);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_next[gi] = blank || (idx_reg != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            an_reg         <= 4'b1111;
            frame_tick_reg <= 1'b0;
        end else begin
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            frame_tick_reg <= frame_end;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with a 4-clock slot: expected per-slot outputs are queued
// alongside each frame's stimulus and compared as the scan reaches each slot.
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       dir_in = 1'b1;
    logic       load = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    slot_t sb[$];

    seg_scan_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .dir_in(dir_in), .load(load),
        .blank(blank), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s3,
                              input logic dp0, input logic blk);
        slot_t e;
        e.an = blk ? 4'b1111 : 4'b1110; e.seg = s0;    e.dp = blk ? 1'b1 : dp0; sb.push_back(e);
        e.an = blk ? 4'b1111 : 4'b1101; e.seg = s1;    e.dp = 1'b1;             sb.push_back(e);
        e.an = blk ? 4'b1111 : 4'b1011; e.seg = 7'h7F; e.dp = 1'b1;             sb.push_back(e);
        e.an = blk ? 4'b1111 : 4'b0111; e.seg = s3;    e.dp = 1'b1;             sb.push_back(e);
    endtask

    // Starts at the negedge where frame_tick is high (or right after reset release);
    // a load scheduled at offset o is sampled at the (o+1)th edge of the frame.
    task automatic run_frame(input string name,
                             input int oa, input logic [3:0] ca, input logic da,
                             input int ob, input logic [3:0] cb, input logic db);
        slot_t e;
        for (int c = 1; c <= 16; c++) begin
            if (oa == c - 1) begin load = 1'b1; count_in = ca; dir_in = da; end
            if (ob == c - 1) begin load = 1'b1; count_in = cb; dir_in = db; end
            @(negedge clk);
            load = 1'b0;
            if ((c % 4 == 1) || (c % 4 == 0)) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s c=%0d scoreboard empty", name, c);
                end else begin
                    e = sb[0];
                    if ({an, seg, dp} !== e) begin
                        errors++;
                        $display("FAIL %s c=%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                                 name, c, an, seg, dp, e.an, e.seg, e.dp);
                    end else begin
                        $display("ok   %s c=%0d an=%b seg=%h dp=%b", name, c, an, seg, dp);
                    end
                    if (c % 4 == 0) e = sb.pop_front();
                end
            end
            if (c == 8 || c == 16) begin
                checks++;
                if (frame_tick !== (c == 16)) begin
                    errors++;
                    $display("FAIL %s frame_tick c=%0d got %b exp %b", name, c, frame_tick, (c == 16));
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({an, seg, dp, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s got an=%b seg=%h dp=%b ft=%b exp an=1111 seg=7f dp=1 ft=0",
                     name, an, seg, dp, frame_tick);
        end else begin
            $display("ok   %s reset outputs", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        push_frame(7'h40, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("reset_scan", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_load_slot1();
        push_frame(7'h40, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("load12_same", 5, 4'd12, 1'b1, -1, 4'd0, 1'b0);
        push_frame(7'h24, 7'h79, 7'h41, 1'b1, 1'b0);
        run_frame("load12_shown", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_two_loads();
        push_frame(7'h24, 7'h79, 7'h41, 1'b1, 1'b0);
        run_frame("two_loads", 2, 4'd5, 1'b0, 10, 4'd9, 1'b0);
        push_frame(7'h10, 7'h7F, 7'h21, 1'b1, 1'b0);
        run_frame("last_load_shown", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_wrap_up();
        push_frame(7'h10, 7'h7F, 7'h21, 1'b1, 1'b0);
        run_frame("load15_up", 3, 4'd15, 1'b1, -1, 4'd0, 1'b0);
        push_frame(7'h12, 7'h79, 7'h41, 1'b1, 1'b0);
        run_frame("show15_up", 7, 4'd0, 1'b1, -1, 4'd0, 1'b0);
        push_frame(7'h40, 7'h7F, 7'h41, 1'b0, 1'b0);
        run_frame("wrap_up_dp", 1, 4'd1, 1'b1, -1, 4'd0, 1'b0);
        push_frame(7'h79, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("wrap_cleared", 0, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_wrap_down_and_boundary();
        push_frame(7'h40, 7'h7F, 7'h21, 1'b1, 1'b0);
        run_frame("show0_down", 9, 4'd15, 1'b0, -1, 4'd0, 1'b0);
        // Load at offset 15 coincides with the boundary edge: must not appear next frame.
        push_frame(7'h12, 7'h79, 7'h21, 1'b0, 1'b0);
        run_frame("wrap_down_dp", 15, 4'd3, 1'b1, -1, 4'd0, 1'b0);
        push_frame(7'h12, 7'h79, 7'h21, 1'b1, 1'b0);
        run_frame("boundary_load_held", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
        push_frame(7'h30, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("boundary_load_shown", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_blank();
        for (int c = 1; c <= 16; c++) begin
            if (c - 1 == 6) blank = 1'b1;
            @(negedge clk);
            if (c == 6) begin
                checks++;
                if (an !== 4'b1101) begin
                    errors++;
                    $display("FAIL blank_before got an=%b exp 1101", an);
                end
            end
            if (c == 7) begin
                checks++;
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL blank_next_cycle got an=%b exp 1111", an);
                end else begin
                    $display("ok   blank_next_cycle an=%b", an);
                end
            end
            if (c == 16) begin
                checks++;
                if (frame_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL blank_tick_period got %b exp 1", frame_tick);
                end
            end
        end
        push_frame(7'h30, 7'h7F, 7'h41, 1'b1, 1'b1);
        run_frame("blanked_frame", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
        blank = 1'b0;
        push_frame(7'h30, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("unblanked_frame", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        for (int c = 1; c <= 7; c++) begin
            if (c - 1 == 3) begin load = 1'b1; count_in = 4'd7; dir_in = 1'b0; end
            @(negedge clk);
            load = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        rst = 1'b0;
        push_frame(7'h40, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("after_reset", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
        push_frame(7'h40, 7'h7F, 7'h41, 1'b1, 1'b0);
        run_frame("pending_lost", -1, 4'd0, 1'b0, -1, 4'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_slot1();
        test_two_loads();
        test_wrap_up();
        test_wrap_down_and_boundary();
        test_blank();
        test_reset_mid_frame();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
